// File: rtl/gold_correlator.sv
// Gold-code correlator: counts chip matches over each code period, reports the
// per-period sum, tracks code-phase lock and requests a one-chip slip on bad periods.
module gold_correlator #(
    parameter int CODE_LEN     = 1023,
    parameter int THRESH       = 768,
    parameter int LOCK_PERIODS = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       chip_en,
    input  logic       epoch,
    input  logic       code_chip,
    input  logic       rx_chip,
    output logic [9:0] sum,
    output logic       sum_valid,
    output logic       locked,
    output logic       slip
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int GW = $clog2(LOCK_PERIODS + 1);
    localparam logic [CW-1:0] LEN_V  = CW'(CODE_LEN);
    localparam logic [CW-1:0] THR_V  = CW'(THRESH);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_PERIODS);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [9:0]    sum_d;
    logic          sum_valid_d, locked_d, slip_d;
    logic          match;

    assign match = ~(rx_chip ^ code_chip);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        sum_d       = sum;
        sum_valid_d = 1'b0;
        slip_d      = 1'b0;
        if (chip_en) begin
            case (state_q)
                IDLE: begin
                    if (epoch) begin
                        acc_d   = CW'(match);
                        cnt_d   = CW'(1);
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (epoch) begin
                        // Epoch chip always opens a fresh period; only a full count reports.
                        acc_d = CW'(match);
                        cnt_d = CW'(1);
                        if (cnt_q == LEN_V) begin
                            sum_d       = 10'(acc_q);
                            sum_valid_d = 1'b1;
                            if (acc_q >= THR_V) begin
                                if (good_q != LOCK_V) good_d = good_q + GW'(1);
                            end else begin
                                good_d = '0;
                                slip_d = 1'b1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end else if (cnt_q == LEN_V) begin
                        // Missing epoch: drop this chip and resynchronise on the next epoch.
                        good_d  = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q + CW'(match);
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (good_d == LOCK_V);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            good_q    <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            locked    <= 1'b0;
            slip      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            sum       <= sum_d;
            sum_valid <= sum_valid_d;
            locked    <= locked_d;
            slip      <= slip_d;
        end
    end

endmodule
